jt900h_intctl: RTL and testbench
================================

# jt900h_intctl

Interrupt controller for the jt900h core. Collects up to NSRC peripheral request lines, latches edge-type requests, resolves priority, and drives the CPU's 3-bit `intrq` level. On CPU acknowledge it freezes the winning source, returns its vector and clears its latch. It sits between the peripherals and the `intrq` input of the jt900h top level.

## Interface

Parameters:
- NSRC, 8: number of request sources, 1..16.
- VBASE, 8'h20: vector of source 0. Source i gets VBASE + 4·i, modulo 256.
- SPUR, 8'hFC: vector returned on a spurious acknowledge.

Ports:
- clk  in  1  system clock. One clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cen  in  1  clock enable. All state advances only when cen=1.
- irq_in  in  NSRC  raw request lines, active high.
- edge_mode  in  NSRC  per source: 1 = rising-edge latched, 0 = level.
- prio  in  3·NSRC  per-source level; source i uses bits [3i+2:3i]. Level 0 disables the source; 7 is highest.
- int_ack  in  1  CPU acceptance strobe, one cen cycle.
- intrq  out  3  highest pending level, registered.
- vector  out  8  vector of the acknowledged source, registered.
- vec_ok  out  1  vector valid, one cen-cycle pulse.

## Operation

- Edge detection:
  - `irq_prev` samples `irq_in` each cen cycle.
  - A rising edge (irq_in & ~irq_prev) on an edge-mode source sets `pend[i]`.
  - `pend[i]` clears only on acknowledge of source i.
- Level sources: effective request = irq_in[i]. They are never latched; the peripheral must drop the line itself.
- Eligibility: a source is eligible when its request is set and prio ≠ 0.
- Arbitration (combinational):
  - Highest prio wins.
  - Ties go to the lowest index.
  - Produces `win_lvl` and `win_idx`. `win_lvl` = 0 when nothing is eligible.
- FSM states:
  - IDLE: intrq <= win_lvl. On int_ack, go to ACK and capture win_idx/win_lvl. If win_lvl = 0 at that moment, the acknowledge is spurious.
  - ACK: vector <= VBASE+4·idx (or SPUR if spurious); vec_ok <= 1; pend[idx] cleared; intrq <= 0. Next state is GAP.
  - GAP: vec_ok <= 0, intrq <= 0. Gives the CPU one cycle to raise its IFF mask. Next state is IDLE.
- int_ack in ACK or GAP is ignored.
- Changing prio or edge_mode while in IDLE takes effect on the next cen cycle; it is not retroactive to latched edges.
- Switching a source from edge to level mode leaves an existing pend bit set until it is acknowledged.

## Timing

- Reset values: intrq=0, vector=0, vec_ok=0, pend=0, irq_prev=0, state=IDLE.
- Edge to intrq:
  - cycle N: edge sampled.
  - cycle N+1: pend set.
  - cycle N+2: intrq valid.
  - Total latency is 2 cen cycles.
- Level to intrq: 1 cen cycle.
- Ack to vector: int_ack at cycle A, then vector/vec_ok at A+1, intrq back to win_lvl no earlier than A+3.
- Simultaneous new edge on the winner and its clear in ACK: set wins, so the request is retained.
- Requests must be held ≥ 1 cen period. Pulses that fall entirely within cen=0 are lost.
- Reset asserted mid-ACK: outputs return to reset values immediately (asynchronous). The vector is lost and the CPU sees intrq=0.

## Structure

- FSM state encodings (IDLE/ACK/GAP) and the vector arithmetic width go in the shared jt900h define/include file alongside the other core constants.
- One natural sub-module: jt900h_intprio, a purely combinational priority resolver (NSRC requests + prio → win_lvl, win_idx). It is reusable by a later micro-DMA trigger selector.
- The top of the block holds the edge latches, FSM and output registers. Expected size is about 150–250 lines total.

## Test plan

- Reset, then source 3 edge-mode, prio=5, rising edge → intrq=5 two cen cycles later. int_ack → next cycle vector=8'h2C, vec_ok=1; then intrq=0 for 2 cycles and stays 0 because pend[3] is cleared.
- Sources 1 and 6 both level, prio=4 each, held high → intrq=4. Ack returns vector 8'h24 (source 1). After GAP, intrq=4 again while the lines stay high.
- Source 2 prio=3 and source 5 prio=6 pending → vector 8'h34 first; the second ack returns 8'h28.
- int_ack with no eligible source → vector=8'hFC, vec_ok=1, all pend bits unchanged.
- New rising edge on source 0 coinciding with its ACK cycle → pend[0] stays set and intrq returns to its level after GAP.
- cen held low for 10 cycles during an edge pulse on source 4 → no pend set. Async rst during ACK → vec_ok=0, intrq=0 in the same cycle.

Source files
------------

// File: rtl/jt900h_intctl_pkg.sv
// jt900h_intctl_pkg: shared constants, FSM encoding and vector helper for the interrupt controller
package jt900h_intctl_pkg;
    localparam int VEC_W = 8;
    localparam int IDX_W = 4;
    localparam int LVL_W = 3;
    typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_GAP} state_t;
    // Vector of source idx: base + 4*idx, wrapping at 256
    function automatic logic [VEC_W-1:0] vec_of(input logic [VEC_W-1:0] base, input logic [IDX_W-1:0] idx);
        return base + {2'b00, idx, 2'b00};
    endfunction
endpackage

// File: rtl/jt900h_intprio.sv
// jt900h_intprio: combinational priority resolver
//   req_i      per-source request
//   prio_i     3-bit level per source, 0 disables
//   win_lvl_o  winning level (0 when nothing eligible)
//   win_idx_o  winning source, lowest index on ties
module jt900h_intprio
    import jt900h_intctl_pkg::*;
#(
    parameter int NSRC = 8
) (
    input  logic [NSRC-1:0]       req_i,
    input  logic [LVL_W*NSRC-1:0] prio_i,
    output logic [LVL_W-1:0]      win_lvl_o,
    output logic [IDX_W-1:0]      win_idx_o
);
    always_comb begin
        win_lvl_o = '0;
        win_idx_o = '0;
        // strict > keeps the earliest index on ties and rejects level 0
        for (int i = 0; i < NSRC; i++)
            if (req_i[i] && prio_i[LVL_W*i +: LVL_W] > win_lvl_o) begin
                win_lvl_o = prio_i[LVL_W*i +: LVL_W];
                win_idx_o = IDX_W'(i);
            end
    end
endmodule

// File: rtl/jt900h_intctl.sv
// jt900h_intctl: interrupt controller feeding the jt900h intrq input
//   clk, rst        clock, asynchronous active-high reset
//   cen_i           clock enable
//   irq_in_i        raw request lines
//   edge_mode_i     1 = rising-edge latched, 0 = level
//   prio_i          3-bit level per source
//   int_ack_i       CPU acknowledge strobe
//   intrq_o         highest pending level
//   vector_o        vector of acknowledged source
//   vec_ok_o        one-cycle vector valid pulse
module jt900h_intctl
    import jt900h_intctl_pkg::*;
#(
    parameter int               NSRC  = 8,
    parameter logic [VEC_W-1:0] VBASE = 8'h20,
    parameter logic [VEC_W-1:0] SPUR  = 8'hFC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cen_i,
    input  logic [NSRC-1:0]       irq_in_i,
    input  logic [NSRC-1:0]       edge_mode_i,
    input  logic [LVL_W*NSRC-1:0] prio_i,
    input  logic                  int_ack_i,
    output logic [LVL_W-1:0]      intrq_o,
    output logic [VEC_W-1:0]      vector_o,
    output logic                  vec_ok_o
);
    state_t            state_q;
    logic [NSRC-1:0]   irq_prev_q, pend_q, pend_d;
    logic [NSRC-1:0]   req, rise, clr;
    logic [LVL_W-1:0]  win_lvl;
    logic [IDX_W-1:0]  win_idx;
    logic              take;

    // A pend bit left over from edge mode still requests after a switch to level
    assign req  = pend_q | (irq_in_i & ~edge_mode_i);
    assign rise = irq_in_i & ~irq_prev_q & edge_mode_i;
    assign take = state_q == ST_IDLE && int_ack_i;
    assign clr  = take && win_lvl != '0 ? NSRC'(1) << win_idx : '0;
    // A new edge in the clearing cycle wins over the clear
    assign pend_d = (pend_q & ~clr) | rise;

    jt900h_intprio #(.NSRC(NSRC)) u_prio (
        .req_i     (req),
        .prio_i    (prio_i),
        .win_lvl_o (win_lvl),
        .win_idx_o (win_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            irq_prev_q <= '0;
            pend_q     <= '0;
            intrq_o    <= '0;
            vector_o   <= '0;
            vec_ok_o   <= 1'b0;
        end else if (cen_i) begin
            irq_prev_q <= irq_in_i;
            pend_q     <= pend_d;
            case (state_q)
                ST_IDLE: begin
                    intrq_o  <= take ? '0 : win_lvl;
                    vec_ok_o <= take;
                    if (take) begin
                        vector_o <= win_lvl != '0 ? vec_of(VBASE, win_idx) : SPUR;
                        state_q  <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    intrq_o  <= '0;
                    vec_ok_o <= 1'b0;
                    state_q  <= ST_GAP;
                end
                default: begin
                    intrq_o  <= '0;
                    vec_ok_o <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jt900h_intctl.sv
// tb_jt900h_intctl: directed self-checking bench for jt900h_intctl
module tb_jt900h_intctl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b1;
    logic [7:0]  irq = '0;
    logic [7:0]  em = '0;
    logic [23:0] prio = '0;
    logic        ack = 1'b0;
    logic [2:0]  intrq;
    logic [7:0]  vector;
    logic        vec_ok;
    int          n_cmp = 0;
    int          n_bad = 0;

    jt900h_intctl dut (
        .clk         (clk),
        .rst         (rst),
        .cen_i       (cen),
        .irq_in_i    (irq),
        .edge_mode_i (em),
        .prio_i      (prio),
        .int_ack_i   (ack),
        .intrq_o     (intrq),
        .vector_o    (vector),
        .vec_ok_o    (vec_ok)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clean();
        irq = '0; em = '0; prio = '0; ack = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        if (intrq !== 3'd0) begin $display("FAIL reset_intrq got=%0d exp=0", intrq); n_bad++; end n_cmp++;
        if (vector !== 8'h00) begin $display("FAIL reset_vector got=%h exp=00", vector); n_bad++; end n_cmp++;
        if (vec_ok !== 1'b0) begin $display("FAIL reset_vec_ok got=%b exp=0", vec_ok); n_bad++; end n_cmp++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_edge();
        em[3] = 1'b1; prio[11:9] = 3'd5; irq[3] = 1'b1;
        tick();
        if (intrq !== 3'd0) begin $display("FAIL edge_lat1 got=%0d exp=0", intrq); n_bad++; end n_cmp++;
        tick();
        if (intrq !== 3'd5) begin $display("FAIL edge_lat2 got=%0d exp=5", intrq); n_bad++; end n_cmp++;
        irq[3] = 1'b0; ack = 1'b1;
        tick();
        ack = 1'b0;
        if (vector !== 8'h2C) begin $display("FAIL edge_vector got=%h exp=2c", vector); n_bad++; end n_cmp++;
        if (vec_ok !== 1'b1) begin $display("FAIL edge_vec_ok got=%b exp=1", vec_ok); n_bad++; end n_cmp++;
        if (intrq !== 3'd0) begin $display("FAIL edge_intrq_ack got=%0d exp=0", intrq); n_bad++; end n_cmp++;
        tick();
        if (vec_ok !== 1'b0) begin $display("FAIL edge_vec_ok_pulse got=%b exp=0", vec_ok); n_bad++; end n_cmp++;
        if (intrq !== 3'd0) begin $display("FAIL edge_intrq_gap got=%0d exp=0", intrq); n_bad++; end n_cmp++;
        tick(); tick();
        if (intrq !== 3'd0) begin $display("FAIL edge_cleared got=%0d exp=0", intrq); n_bad++; end n_cmp++;
        clean();
    endtask

    task automatic test_level();
        prio[5:3] = 3'd4; prio[20:18] = 3'd4; irq[1] = 1'b1; irq[6] = 1'b1;
        tick();
        if (intrq !== 3'd4) begin $display("FAIL level_intrq got=%0d exp=4", intrq); n_bad++; end n_cmp++;
        ack = 1'b1;
        tick();
        if (vector !== 8'h24) begin $display("FAIL level_vector got=%h exp=24", vector); n_bad++; end n_cmp++;
        if (vec_ok !== 1'b1) begin $display("FAIL level_vec_ok got=%b exp=1", vec_ok); n_bad++; end n_cmp++;
        tick();
        ack = 1'b0;
        if (vec_ok !== 1'b0) begin $display("FAIL level_ack_ignored got=%b exp=0", vec_ok); n_bad++; end n_cmp++;
        tick();
        if (intrq !== 3'd0) begin $display("FAIL level_gap got=%0d exp=0", intrq); n_bad++; end n_cmp++;
        tick();
        if (intrq !== 3'd4) begin $display("FAIL level_reassert got=%0d exp=4", intrq); n_bad++; end n_cmp++;
        irq = '0;
        tick();
        if (intrq !== 3'd0) begin $display("FAIL level_drop got=%0d exp=0", intrq); n_bad++; end n_cmp++;
        clean();
    endtask

    task automatic test_priority();
        em[2] = 1'b1; em[5] = 1'b1; prio[8:6] = 3'd3; prio[17:15] = 3'd6;
        irq[2] = 1'b1; irq[5] = 1'b1;
        tick();
        irq = '0;
        tick();
        if (intrq !== 3'd6) begin $display("FAIL prio_intrq got=%0d exp=6", intrq); n_bad++; end n_cmp++;
        ack = 1'b1; tick(); ack = 1'b0;
        if (vector !== 8'h34) begin $display("FAIL prio_vector1 got=%h exp=34", vector); n_bad++; end n_cmp++;
        tick(); tick(); tick();
        if (intrq !== 3'd3) begin $display("FAIL prio_second got=%0d exp=3", intrq); n_bad++; end n_cmp++;
        ack = 1'b1; tick(); ack = 1'b0;
        if (vector !== 8'h28) begin $display("FAIL prio_vector2 got=%h exp=28", vector); n_bad++; end n_cmp++;
        tick(); tick(); tick();
        if (intrq !== 3'd0) begin $display("FAIL prio_empty got=%0d exp=0", intrq); n_bad++; end n_cmp++;
        clean();
    endtask

    task automatic test_spurious();
        em[7] = 1'b1; irq[7] = 1'b1;
        tick();
        irq[7] = 1'b0;
        tick();
        if (intrq !== 3'd0) begin $display("FAIL spur_idle got=%0d exp=0", intrq); n_bad++; end n_cmp++;
        ack = 1'b1; tick(); ack = 1'b0;
        if (vector !== 8'hFC) begin $display("FAIL spur_vector got=%h exp=fc", vector); n_bad++; end n_cmp++;
        if (vec_ok !== 1'b1) begin $display("FAIL spur_vec_ok got=%b exp=1", vec_ok); n_bad++; end n_cmp++;
        tick(); tick(); tick();
        prio[23:21] = 3'd2;
        tick();
        if (intrq !== 3'd2) begin $display("FAIL spur_pend_kept got=%0d exp=2", intrq); n_bad++; end n_cmp++;
        ack = 1'b1; tick(); ack = 1'b0;
        if (vector !== 8'h3C) begin $display("FAIL spur_vector7 got=%h exp=3c", vector); n_bad++; end n_cmp++;
        tick(); tick(); tick();
        if (intrq !== 3'd0) begin $display("FAIL spur_cleared got=%0d exp=0", intrq); n_bad++; end n_cmp++;
        clean();
    endtask

    task automatic test_back_to_back();
        em[0] = 1'b1; prio[2:0] = 3'd7; irq[0] = 1'b1;
        tick();
        irq[0] = 1'b0;
        tick();
        if (intrq !== 3'd7) begin $display("FAIL b2b_intrq got=%0d exp=7", intrq); n_bad++; end n_cmp++;
        ack = 1'b1; irq[0] = 1'b1;
        tick();
        ack = 1'b0; irq[0] = 1'b0;
        if (vector !== 8'h20) begin $display("FAIL b2b_vector got=%h exp=20", vector); n_bad++; end n_cmp++;
        tick(); tick();
        if (intrq !== 3'd0) begin $display("FAIL b2b_gap got=%0d exp=0", intrq); n_bad++; end n_cmp++;
        tick();
        if (intrq !== 3'd7) begin $display("FAIL b2b_retained got=%0d exp=7", intrq); n_bad++; end n_cmp++;
        ack = 1'b1; tick(); ack = 1'b0;
        if (vec_ok !== 1'b1) begin $display("FAIL b2b_second_ack got=%b exp=1", vec_ok); n_bad++; end n_cmp++;
        tick(); tick(); tick();
        if (intrq !== 3'd0) begin $display("FAIL b2b_cleared got=%0d exp=0", intrq); n_bad++; end n_cmp++;
        clean();
    endtask

    task automatic test_cen();
        cen = 1'b0; em[4] = 1'b1; prio[14:12] = 3'd5; irq[4] = 1'b1;
        repeat (5) tick();
        irq[4] = 1'b0;
        repeat (5) tick();
        cen = 1'b1;
        tick(); tick();
        if (intrq !== 3'd0) begin $display("FAIL cen_lost got=%0d exp=0", intrq); n_bad++; end n_cmp++;
        clean();
    endtask

    task automatic test_async_reset();
        prio[5:3] = 3'd3; irq[1] = 1'b1;
        tick();
        if (intrq !== 3'd3) begin $display("FAIL arst_pre got=%0d exp=3", intrq); n_bad++; end n_cmp++;
        ack = 1'b1; tick(); ack = 1'b0;
        if (vec_ok !== 1'b1) begin $display("FAIL arst_ack got=%b exp=1", vec_ok); n_bad++; end n_cmp++;
        #2 rst = 1'b1;
        #1;
        if (vec_ok !== 1'b0) begin $display("FAIL arst_vec_ok got=%b exp=0", vec_ok); n_bad++; end n_cmp++;
        if (intrq !== 3'd0) begin $display("FAIL arst_intrq got=%0d exp=0", intrq); n_bad++; end n_cmp++;
        if (vector !== 8'h00) begin $display("FAIL arst_vector got=%h exp=00", vector); n_bad++; end n_cmp++;
        rst = 1'b0;
        clean();
    endtask

    initial begin
        test_reset();
        test_edge();
        test_level();
        test_priority();
        test_spurious();
        test_back_to_back();
        test_cen();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
